debounce_sync: RTL

//   Conditions a raw asynchronous input (push-button or switch) into a clean,

---
 rtl/debounce_sync_if.sv | 12 +
 rtl/debounce_sync.sv | 117 +++++++++++
 2 files changed

// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw board input and its debouncer: the raw level in,
// and the debounced level, edge strobes and busy flag out.
interface debounce_sync_if;
  logic btn_in;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (output btn_in, input d_out, rise_pulse, fall_pulse, busy);
  modport slave  (input btn_in, output d_out, rise_pulse, fall_pulse, busy);
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus stability counter and 4-state FSM that turns a
// bouncing asynchronous input into a clean level with one-cycle edge strobes.
module debounce_sync #(
  parameter int   STABLE_CYCLES = 50000,
  parameter int   CNT_W         = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input logic             clk,
  input logic             rst,
  debounce_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam state_t           RESET_STATE = RESET_LEVEL ? IDLE_HI : IDLE_LO;

  logic             sync1, sync2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             d_q, d_n;
  logic             rise_q, rise_n;
  logic             fall_q, fall_n;
  logic             busy_q, busy_n;

  // NOTE: every flop here uses <= so all registers update from pre-edge values;
  // blocking = would let sync2 see this edge's sync1 and collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= RESET_LEVEL;
      sync2  <= RESET_LEVEL;
      state  <= RESET_STATE;
      cnt    <= '0;
      d_q    <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sync1  <= bus.btn_in;
      sync2  <= sync1;
      state  <= state_n;
      cnt    <= cnt_n;
      d_q    <= d_n;
      rise_q <= rise_n;
      fall_q <= fall_n;
      busy_q <= busy_n;
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_n     = d_q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;

    unique case (state)
      IDLE_LO: begin
        if (sync2) begin
          state_n = WAIT_HI;
          cnt_n   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync2) begin
          state_n = IDLE_LO;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_HI;
          cnt_n   = '0;
          d_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!sync2) begin
          state_n = WAIT_LO;
          cnt_n   = '0;
        end
      end
      WAIT_LO: begin
        if (sync2) begin
          state_n = IDLE_HI;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_LO;
          cnt_n   = '0;
          d_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = RESET_STATE;
        cnt_n   = '0;
      end
    endcase

    // busy is registered from the next state so it tracks WAIT residency exactly
    busy_n = (state_n == WAIT_HI) || (state_n == WAIT_LO);
  end

  assign bus.d_out      = d_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;

endmodule
